// File: rtl/lab5_1_countdown_pkg.sv
// Shared lab5 definitions: BCD digit type, enable encoding and default preset.
package lab5_1_countdown_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Same encoding as the start/pause FSM's count_enable output.
  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  localparam bcd_t DEFAULT_PRESET_TENS = 4'd3;
  localparam bcd_t DEFAULT_PRESET_ONES = 4'd0;

  // One BCD step down: 0 wraps to 9 (the caller raises the borrow).
  function automatic bcd_t bcd_dec(input bcd_t d);
    return (d == '0) ? BCD_MAX : bcd_t'(d - 4'd1);
  endfunction

endpackage

// File: rtl/lab5_1_countdown_digit.sv
// One BCD down-counting digit with load and a combinational borrow towards the next digit.
module bcd_down_digit
  import lab5_1_countdown_pkg::*;
(
  input  logic clk,
  input  logic rst_n,       // active-high synchronous reset
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  output bcd_t q,
  output logic borrow_out
);

  bcd_t q_q, q_d;

  // Next digit value: load beats decrement, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec) begin
      q_d = bcd_dec(q_q);
    end
  end

  // Digit register; reset reloads the preset just like load.
  always_ff @(posedge clk) begin
    // NOTE: rst_n is high-true here and sampled on the clock edge; it is not an async clear.
    if (rst_n) begin
      q_q <= load_val;
    end else begin
      // NOTE: state uses <= so every flop samples pre-edge values; = in always_ff creates order races.
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec & (q_q == '0);

endmodule

// File: rtl/lab5_1_countdown.sv
// Two-digit BCD seconds countdown with its own 1 Hz prescaler and a terminal-count done flag.
module lab5_1_countdown
  import lab5_1_countdown_pkg::*;
#(
  parameter int   DIV         = 100_000_000,
  parameter bcd_t PRESET_TENS = DEFAULT_PRESET_TENS,
  parameter bcd_t PRESET_ONES = DEFAULT_PRESET_ONES
) (
  input  logic clk,
  input  logic rst_n,          // active-high synchronous reset
  input  logic count_enable,
  input  logic load,
  output bcd_t digit_tens,
  output bcd_t digit_ones,
  output logic done
);

  localparam int            PS_W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(DIV - 1);
  localparam logic          PRESET_ZERO = (PRESET_TENS == '0) && (PRESET_ONES == '0);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            done_q, done_d;
  logic            run, tick;
  logic            ones_borrow;
  // The tens digit never borrows: done stops the ticks once the count is 00.
  logic            unused_tens_borrow;
  bcd_t            ones_q, tens_q;

  // Prescaler advance, tick generation and terminal-count detection.
  always_comb begin
    run    = (count_enable == ENABLED) & ~done_q;
    tick   = run & (ps_q == PS_LAST);
    ps_d   = ps_q;
    done_d = done_q;
    if (load) begin
      ps_d   = '0;
      done_d = PRESET_ZERO;
    end else if (tick) begin
      ps_d = '0;
      if (tens_q == '0 && ones_q == 4'd1) begin
        done_d = 1'b1;
      end
    end else if (run) begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  // Prescaler and done registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ps_q   <= '0;
      done_q <= PRESET_ZERO;
    end else begin
      ps_q   <= ps_d;
      done_q <= done_d;
    end
  end

  bcd_down_digit u_ones (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (PRESET_ONES),
    .dec        (tick),
    .q          (ones_q),
    .borrow_out (ones_borrow)
  );

  bcd_down_digit u_tens (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (PRESET_TENS),
    .dec        (ones_borrow),
    .q          (tens_q),
    .borrow_out (unused_tens_borrow)
  );

  assign digit_tens = tens_q;
  assign digit_ones = ones_q;
  assign done       = done_q;

endmodule
